// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and sequencer state encoding.
package cnn_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, FIN} state_e;

    localparam int CONV2_NUM_FILTERS = 10;
    localparam int CONV2_OUT_LEN     = 32;
    localparam int DATA_W            = 32;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/conv2_bias_sat_add.sv
// Combinational signed add with clamp to the DATA_W two's complement range.
// Shared by the conv1, conv2 and dense bias stages.
module sat_add #(
    parameter int DATA_W = 32
) (
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [DATA_W-1:0] sum_o
);

    logic [DATA_W:0] sum;

    assign sum = {a_i[DATA_W-1], a_i} + {b_i[DATA_W-1], b_i};

    // Overflow is visible as disagreement between the guard bit and the MSB.
    always_comb begin
        sum_o = sum[DATA_W-1:0];
        if (sum[DATA_W] != sum[DATA_W-1])
            sum_o = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end

endmodule

// File: rtl/conv2_bias_seq.sv
// Conv2 bias sequencer: walks filters, latches each bias, adds it with
// saturation to the psum stream. Define CONV2_BIAS_RELU_EN to clamp negatives to 0.
module conv2_bias_seq #(
    parameter int NUM_FILTERS = cnn_pkg::CONV2_NUM_FILTERS,
    parameter int OUT_LEN     = cnn_pkg::CONV2_OUT_LEN,
    parameter int DATA_W      = cnn_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [3:0]        output_filter,
    input  logic [DATA_W-1:0] b,
    input  logic              psum_valid,
    input  logic [DATA_W-1:0] psum_data,
    output logic              psum_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              filter_last,
    output logic              busy,
    output logic              done
);
    import cnn_pkg::*;

    localparam int              PW        = $clog2(OUT_LEN);
    localparam logic [PW-1:0]   POS_LAST  = PW'(OUT_LEN - 1);
    localparam logic [3:0]      FILT_LAST = 4'(NUM_FILTERS - 1);

    state_e            state_q;
    logic [3:0]        filt_q;
    logic [DATA_W-1:0] bias_q;
    logic [PW-1:0]     pos_q;
    logic              ov_q;
    logic [DATA_W-1:0] od_q;
    logic              fl_q;
    logic              done_q;

    logic [DATA_W-1:0] sat_res;
    logic [DATA_W-1:0] res;
    logic              psum_hs;
    logic              last_pos;

    sat_add #(.DATA_W(DATA_W)) u_sat (
        .a_i   (psum_data),
        .b_i   (bias_q),
        .sum_o (sat_res)
    );

`ifdef CONV2_BIAS_RELU_EN
    assign res = sat_res[DATA_W-1] ? '0 : sat_res;
`else
    assign res = sat_res;
`endif

    assign psum_ready    = (state_q == RUN) && (!ov_q || out_ready);
    assign psum_hs       = psum_ready && psum_valid;
    assign last_pos      = (pos_q == POS_LAST);
    assign output_filter = filt_q;
    assign out_valid     = ov_q;
    assign out_data      = od_q;
    assign filter_last   = fl_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            filt_q  <= '0;
            bias_q  <= '0;
            pos_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            fl_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Output register runs in every state so the final result drains after RUN.
            if (psum_hs) begin
                ov_q  <= 1'b1;
                od_q  <= res;
                fl_q  <= last_pos;
                pos_q <= last_pos ? '0 : pos_q + PW'(1);
            end else if (out_ready) begin
                ov_q <= 1'b0;
            end

            case (state_q)
                IDLE: if (start) begin
                    filt_q  <= '0;
                    state_q <= LOAD;
                end
                LOAD: begin
                    bias_q  <= b;
                    pos_q   <= '0;
                    state_q <= RUN;
                end
                RUN: if (psum_hs && last_pos) begin
                    if (filt_q == FILT_LAST) begin
                        state_q <= DRAIN;
                    end else begin
                        filt_q  <= filt_q + 4'd1;
                        state_q <= LOAD;
                    end
                end
                DRAIN: if (!ov_q || out_ready) begin
                    done_q  <= 1'b1;
                    filt_q  <= '0;
                    state_q <= FIN;
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2_bias_seq.sv
// Scoreboard bench for conv2_bias_seq with a saturating-add reference model.
module tb_conv2_bias_seq;

    localparam int NF  = 2;
    localparam int OL  = 4;
    localparam int DW  = 32;
    localparam int TOT = NF * OL;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    output_filter;
    logic [DW-1:0] b;
    logic          psum_valid = 1'b0;
    logic [DW-1:0] psum_data = '0;
    logic          psum_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b1;
    logic          filter_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] bias_tbl [16];
    logic [DW-1:0] ps [TOT];

    typedef struct { logic [DW-1:0] d; logic l; } exp_t;
    exp_t exp_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int ncyc = 0;
    int done_cnt = 0;

    assign b = bias_tbl[output_filter];

    conv2_bias_seq #(.NUM_FILTERS(NF), .OUT_LEN(OL), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .output_filter (output_filter),
        .b             (b),
        .psum_valid    (psum_valid),
        .psum_data     (psum_data),
        .psum_ready    (psum_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .filter_last   (filter_last),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;
    always @(negedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference: exact integer sum, clamped to the signed range, optional ReLU.
    function automatic logic [DW-1:0] ref_out(input logic [DW-1:0] p, input logic [DW-1:0] bb);
        longint s;
        s = longint'($signed(p)) + longint'($signed(bb));
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
`ifdef CONV2_BIAS_RELU_EN
        if (s < 0) s = 0;
`endif
        return s[DW-1:0];
    endfunction

    // Monitor: pops the scoreboard on each output handshake and checks stall stability.
    initial begin
        logic          pv;
        logic [DW-1:0] pd;
        exp_t          e;
        pv = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv) begin
                    chk("stall_valid_hold", out_valid, 1);
                    chk("stall_data_hold", out_data, pd);
                end
                if (out_valid && !out_ready) chk("stall_psum_ready", psum_ready, 0);
                pv = out_valid && !out_ready;
                pd = out_data;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", out_data, 64'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("filter_last", filter_last, e.l);
                    end
                end
                if (done) done_cnt++;
            end
        end
    end

    // rmode: 0 always ready, 1 three-cycle stall mid-stream, 2 random.
    task automatic run_pass(input bit rnd_valid, input int rmode, input bit mid_start,
                            input bit abort, input bit chk_gap);
        int  i, guard, stall_left, last_hs, expf;
        bit  chk_load, stalled, seen;
        exp_t e;
        i = 0; guard = 0; stall_left = 0; last_hs = 0; expf = 0;
        chk_load = 0; stalled = 0; seen = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        psum_valid = !rnd_valid;
        psum_data  = ps[0];
        #1;
        chk("load0_filter", output_filter, 0);
        chk("load0_psum_ready", psum_ready, 0);
        chk("load0_busy", busy, 1);
        @(negedge clk);
        while (i < TOT && guard < 400) begin
            guard++;
            if (rmode == 1 && i == 5 && !stalled) begin
                stalled = 1; stall_left = 3;
            end
            if (rmode == 1) begin
                out_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end else if (rmode == 2) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                out_ready = 1'b1;
            end
            psum_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            psum_data  = ps[i];
            start      = mid_start && (i == 5);
            #1;
            if (chk_load) begin
                chk("load_filter", output_filter, expf);
                chk("load_psum_ready", psum_ready, 0);
                chk_load = 0;
            end
            if (psum_valid && psum_ready) begin
                e.d = ref_out(ps[i], bias_tbl[i / OL]);
                e.l = ((i % OL) == OL - 1);
                exp_q.push_back(e);
                if ((i % OL) == OL - 1 && i != TOT - 1) begin
                    chk_load = 1; expf = i / OL + 1;
                end
                last_hs = ncyc;
                i++;
            end
            if (abort && i == 5) begin
                #2;
                rst = 1'b1;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_psum_ready", psum_ready, 0);
                chk("rst_filter", output_filter, 0);
                exp_q.delete();
                @(negedge clk);
                rst = 1'b0;
                psum_valid = 1'b0;
                start = 1'b0;
                out_ready = 1'b1;
                return;
            end
            @(negedge clk);
        end
        chk("pass_psums_accepted", i, TOT);
        psum_valid = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            #3;
            if (done) begin
                seen = 1;
                if (chk_gap) chk("done_gap", ncyc - last_hs, 2);
                if (mid_start) start = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", seen, 1);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk("idle_after_pass", busy, 0);
        chk("done_pulse_count", done_cnt, 1);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic rand_fill();
        for (int f = 0; f < 16; f++) bias_tbl[f] = $urandom;
        for (int k = 0; k < TOT; k++) ps[k] = $urandom;
    endtask

    initial begin
        for (int f = 0; f < 16; f++) bias_tbl[f] = '0;
        for (int k = 0; k < TOT; k++) ps[k] = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_filter", output_filter, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_filter_last", filter_last, 0);
        chk("reset_done", done, 0);
        chk("reset_psum_ready", psum_ready, 0);
        rst = 1'b0;

        // Basic pass: biases 100 / -50, psums 1..4 per filter.
        bias_tbl[0] = 32'd100;
        bias_tbl[1] = -32'sd50;
        for (int k = 0; k < TOT; k++) ps[k] = 32'(k % OL + 1);
        run_pass(0, 0, 0, 0, 1);

        // Saturation corners, including exact-limit results.
        bias_tbl[0] = 32'h7FFFFF00;
        bias_tbl[1] = 32'h80000010;
        ps[0] = 32'h200; ps[1] = 32'h100; ps[2] = 32'hFF;  ps[3] = -32'sd5;
        ps[4] = -32'sh20; ps[5] = -32'sh10; ps[6] = 32'd1; ps[7] = 32'h7FFFFFFF;
        run_pass(0, 0, 0, 0, 1);

        // ReLU-sensitive values.
        bias_tbl[0] = -32'sd50;
        bias_tbl[1] = 32'd5;
        for (int k = 0; k < TOT; k++) ps[k] = 32'd10;
        run_pass(0, 0, 0, 0, 1);

        rand_fill();
        run_pass(0, 1, 0, 0, 0);

        rand_fill();
        run_pass(1, 2, 1, 0, 0);
        rand_fill();
        run_pass(1, 2, 0, 0, 0);

        rand_fill();
        run_pass(0, 0, 0, 1, 0);
        rand_fill();
        run_pass(1, 1, 0, 0, 0);

        for (int r = 0; r < 3; r++) begin
            rand_fill();
            run_pass(1, 2, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
